// File: rtl/tour_pkg.sv
// Shared types and constants for the tour command sequencer and its bench.
package tour_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;

  // Positive acknowledge byte returned by RemoteComm.
  localparam logic [RESP_W-1:0] ACK_BYTE = 8'hA5;

  // Command opcodes used by the tour scripts.
  localparam logic [CMD_W-1:0] CMD_CAL_GYRO = 16'h2000;
  localparam logic [CMD_W-1:0] CMD_MOVE_A   = 16'h4002;
  localparam logic [CMD_W-1:0] CMD_MOVE_B   = 16'h5BF1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SNT  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_NAK   = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_EMPTY = 2'd3
  } err_code_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-2 depth, occupancy counter, flush beats push.
module cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q & ~flush;
  assign pop_ok  = pop & ~empty_q & ~flush;
  assign head_c  = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end
  end

  // Pointer, counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays queued tour commands into RemoteComm, one at a time, gated on acks.
module tour_cmd_sequencer
  import tour_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TMO_CLKS = 50_000_000,
  parameter logic [7:0]  ACK      = ACK_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_cmd,
  output logic        full,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  cmds_done
);

  localparam int unsigned TW = (TMO_CLKS > 2) ? $clog2(TMO_CLKS) : 1;

  seq_state_t      state_q, state_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            snd_q, snd_d;
  logic            busy_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  err_code_t       err_code_q, err_code_d;
  logic [7:0]      cmds_done_q, cmds_done_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_resp_q, pend_resp_d;

  logic            pop_c;
  logic [15:0]     fifo_head;
  logic            fifo_full, fifo_empty;
  logic            rsp_hit;
  logic [7:0]      rsp_byte;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop_c),
    .head_c    (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A response captured while still in WAIT_SNT takes precedence over a live one.
  assign rsp_hit  = resp_rdy | pend_q;
  assign rsp_byte = pend_q ? pend_resp_q : resp;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    snd_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;
    cmds_done_d = cmds_done_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    pend_resp_d = pend_resp_q;
    pop_c       = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      tmo_d      = '0;
      pend_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (fifo_empty) begin
              state_d    = ST_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_EMPTY;
            end else begin
              state_d     = ST_SEND;
              cmds_done_d = '0;
            end
          end
        end
        ST_SEND: begin
          pop_c   = 1'b1;
          cmd_d   = fifo_head;
          snd_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_WAIT_SNT;
        end
        ST_WAIT_SNT: begin
          if (resp_rdy) begin
            pend_d      = 1'b1;
            pend_resp_d = resp;
          end
          if (cmd_snt) begin
            state_d = ST_WAIT_RESP;
            tmo_d   = '0;
          end
        end
        ST_WAIT_RESP: begin
          pend_d = 1'b0;
          if (rsp_hit) begin
            if (rsp_byte == ACK) begin
              cmds_done_d = sat_inc8(cmds_done_q);
              state_d     = fifo_empty ? ST_DONE : ST_SEND;
            end else begin
              state_d    = ST_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_NAK;
            end
          end else if (tmo_q == TW'(TMO_CLKS - 1)) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      snd_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cmds_done_q <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_resp_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      snd_q       <= snd_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cmds_done_q <= cmds_done_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      pend_resp_q <= pend_resp_d;
    end
  end

  assign full      = fifo_full;
  assign cmd       = cmd_q;
  assign snd_cmd   = snd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cmds_done = cmds_done_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: queue model + scoreboard monitor + RemoteComm responder.
module tb_tour_cmd_sequencer;
  import tour_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] push_cmd;
  logic        full;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  cmds_done;

  int total = 0;
  int bad   = 0;

  // Model FIFO: the commands the DUT is expected to send, in order.
  logic [15:0] mdl_q[$];
  // Response bytes to return, one per command; ACK when exhausted.
  logic [7:0]  rsp_seq[$];
  int          rsp_mode = 0;
  bit          quiet    = 1'b0;
  int          done_cnt = 0;
  int          snd_cnt  = 0;
  bit          prev_done = 1'b0;
  bit          prev_snd  = 1'b0;
  logic [15:0] exp_cmd;
  logic [7:0]  rb;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_CLKS(TMO), .ACK(ACK_BYTE)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_cmd  (push_cmd),
    .full      (full),
    .start     (start),
    .abort     (abort),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .cmd_snt   (cmd_snt),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cmds_done (cmds_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every snd_cmd must carry the model's next command.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
        prev_snd  = 1'b0;
      end else begin
        if (snd_cmd) begin
          snd_cnt++;
          check("snd_allowed", 32'(!quiet && mdl_q.size() > 0), 1);
          check("snd_width", 32'(prev_snd), 0);
          if (!quiet && mdl_q.size() > 0) begin
            exp_cmd = mdl_q.pop_front();
            check("cmd_order", 32'(cmd), 32'(exp_cmd));
          end
        end
        if (prev_done) check("busy_after_done", 32'(busy), 0);
        if (done) begin
          done_cnt++;
          check("done_width", 32'(prev_done), 0);
        end
        prev_done = done;
        prev_snd  = snd_cmd;
      end
    end
  end

  // RemoteComm stand-in: reacts to each snd_cmd according to rsp_mode.
  initial begin
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    resp     = '0;
    forever begin
      @(negedge clk);
      if (snd_cmd) begin
        rb = (rsp_seq.size() > 0) ? rsp_seq.pop_front() : ACK_BYTE;
        case (rsp_mode)
          1: begin // cmd_snt and response together
            cmd_snt = 1'b1; resp_rdy = 1'b1; resp = rb;
            @(negedge clk);
            cmd_snt = 1'b0; resp_rdy = 1'b0;
          end
          2: begin // withhold response: timeout must hit exactly TMO clocks in
            cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
            repeat (TMO - 1) @(negedge clk);
            check("tmo_not_early", 32'(err), 0);
            @(negedge clk);
            check("tmo_err", 32'(err), 1);
            check("tmo_code", 32'(err_code), 2);
          end
          3: begin // response before cmd_snt
            resp_rdy = 1'b1; resp = rb;
            @(negedge clk);
            resp_rdy = 1'b0; cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
          end
          4: begin // response on the timeout-expiry cycle
            cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
            repeat (TMO - 1) @(negedge clk);
            resp_rdy = 1'b1; resp = rb;
            @(negedge clk);
            resp_rdy = 1'b0;
            check("expiry_ack_no_err", 32'(err), 0);
          end
          5: begin // long wait for the response
            cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
            repeat (20) @(negedge clk);
            resp_rdy = 1'b1; resp = rb;
            @(negedge clk);
            resp_rdy = 1'b0;
          end
          6: begin // cmd_snt only, no response, no checks
            cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
          end
          default: begin // random gaps
            repeat ($urandom_range(0, 3)) @(negedge clk);
            cmd_snt = 1'b1;
            @(negedge clk);
            cmd_snt = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            resp_rdy = 1'b1; resp = rb;
            @(negedge clk);
            resp_rdy = 1'b0;
          end
        endcase
      end
    end
  end

  task automatic push_one(input logic [15:0] c, input bit with_abort);
    push = 1'b1; push_cmd = c; abort = with_abort;
    if (with_abort) mdl_q.delete();
    else if (mdl_q.size() < DEPTH) mdl_q.push_back(c);
    @(negedge clk);
    push = 1'b0; abort = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    mdl_q.delete();
    rsp_seq.delete();
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while ((busy || done) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < lim), 1);
  endtask

  task automatic wait_err(input string name, input int lim);
    int n = 0;
    while (!err && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < lim), 1);
  endtask

  initial begin
    int d0, s0, n, extra;
    logic [15:0] c;
    rst = 1'b1; push = 1'b0; push_cmd = '0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_snd", 32'(snd_cmd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_cnt", 32'(cmds_done), 0);
    check("rst_full", 32'(full), 0);
    rst = 1'b0;
    @(negedge clk);

    // Three scripted commands, all acked.
    rsp_mode = 0;
    push_one(CMD_CAL_GYRO, 1'b0);
    push_one(CMD_MOVE_A, 1'b0);
    push_one(CMD_MOVE_B, 1'b0);
    d0 = done_cnt; s0 = snd_cnt;
    pulse_start();
    check("lat_first", 32'(snd_cmd), 0);
    check("busy_rise", 32'(busy), 1);
    @(negedge clk);
    check("lat_second", 32'(snd_cmd), 1);
    wait_idle("run3_end", 500);
    check("run3_cnt", 32'(cmds_done), 3);
    check("run3_snd", 32'(snd_cnt - s0), 3);
    check("run3_done", 32'(done_cnt - d0), 1);
    check("run3_left", 32'(mdl_q.size()), 0);
    check("run3_err", 32'(err), 0);

    // NAK on second command; remaining command preserved, start ignored.
    rsp_seq.push_back(ACK_BYTE);
    rsp_seq.push_back(8'h5A);
    push_one(CMD_MOVE_A, 1'b0);
    push_one(CMD_MOVE_B, 1'b0);
    push_one(CMD_CAL_GYRO, 1'b0);
    pulse_start();
    wait_err("nak_wait", 500);
    quiet = 1'b1;
    check("nak_code", 32'(err_code), 1);
    check("nak_cnt", 32'(cmds_done), 1);
    check("nak_busy", 32'(busy), 1);
    pulse_start();
    repeat (10) @(negedge clk);
    check("nak_sticky", 32'(err), 1);
    check("nak_sticky_code", 32'(err_code), 1);
    do_abort();
    check("abort_err", 32'(err), 0);
    check("abort_code", 32'(err_code), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_keep_cnt", 32'(cmds_done), 1);
    check("abort_keep_cmd", 32'(cmd), 32'(CMD_MOVE_B));

    // Push together with abort is dropped, so start finds an empty FIFO.
    push_one(16'h1234, 1'b1);
    pulse_start();
    check("empty_err", 32'(err), 1);
    check("empty_code", 32'(err_code), 3);
    repeat (3) @(negedge clk);
    do_abort();
    quiet = 1'b0;

    // Timeout, then response exactly on the expiry cycle.
    rsp_mode = 2;
    push_one(CMD_MOVE_A, 1'b0);
    pulse_start();
    wait_err("tmo_wait", 500);
    check("tmo_cnt", 32'(cmds_done), 0);
    repeat (2) @(negedge clk);
    do_abort();
    rsp_mode = 4;
    push_one(CMD_MOVE_B, 1'b0);
    pulse_start();
    wait_idle("expiry_end", 500);
    check("expiry_cnt", 32'(cmds_done), 1);
    check("expiry_err", 32'(err), 0);

    // Fill past DEPTH: last push dropped, exactly DEPTH replayed.
    rsp_mode = 0;
    for (int i = 0; i < int'(DEPTH); i++) push_one(16'($urandom), 1'b0);
    check("full_set", 32'(full), 1);
    push_one(16'hDEAD, 1'b0);
    check("full_hold", 32'(full), 1);
    s0 = snd_cnt;
    pulse_start();
    wait_idle("full_end", 2000);
    check("full_cnt", 32'(cmds_done), DEPTH);
    check("full_snd", 32'(snd_cnt - s0), DEPTH);
    check("full_clear", 32'(full), 0);

    // start during WAIT_RESP is ignored.
    rsp_mode = 5;
    push_one(CMD_CAL_GYRO, 1'b0);
    s0 = snd_cnt;
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_idle("ign_end", 500);
    check("ign_cnt", 32'(cmds_done), 1);
    check("ign_snd", 32'(snd_cnt - s0), 1);
    check("ign_err", 32'(err), 0);

    // Pending-flag paths: response with or before cmd_snt.
    rsp_mode = 1;
    push_one(CMD_MOVE_A, 1'b0);
    push_one(CMD_MOVE_B, 1'b0);
    pulse_start();
    wait_idle("pend_same_end", 500);
    check("pend_same_cnt", 32'(cmds_done), 2);
    rsp_mode = 3;
    push_one(CMD_MOVE_B, 1'b0);
    push_one(CMD_MOVE_A, 1'b0);
    pulse_start();
    wait_idle("pend_early_end", 500);
    check("pend_early_cnt", 32'(cmds_done), 2);

    // Reset in the middle of WAIT_RESP.
    rsp_mode = 6;
    push_one(CMD_MOVE_A, 1'b0);
    push_one(CMD_MOVE_B, 1'b0);
    pulse_start();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    mdl_q.delete();
    @(negedge clk);
    check("mrst_cmd", 32'(cmd), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_err", 32'(err), 0);
    check("mrst_cnt", 32'(cmds_done), 0);
    check("mrst_snd", 32'(snd_cmd), 0);
    rst = 1'b0;
    quiet = 1'b1;
    pulse_start();
    check("mrst_empty_code", 32'(err_code), 3);
    do_abort();
    quiet = 1'b0;

    // Randomized replays with occasional mid-run appends.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, DEPTH);
      case ($urandom_range(0, 2))
        0:       rsp_mode = 0;
        1:       rsp_mode = 1;
        default: rsp_mode = 3;
      endcase
      for (int i = 0; i < n; i++) begin
        c = 16'($urandom);
        push_one(c, 1'b0);
      end
      d0 = done_cnt;
      pulse_start();
      extra = 0;
      if (n <= int'(DEPTH) - 2 && $urandom_range(0, 1) == 1) begin
        push_one(16'($urandom), 1'b0);
        extra = 1;
      end
      wait_idle("rnd_end", 2000);
      check("rnd_cnt", 32'(cmds_done), 32'(n + extra));
      check("rnd_done", 32'(done_cnt - d0), 1);
      check("rnd_left", 32'(mdl_q.size()), 0);
      check("rnd_err", 32'(err), 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
